// File: rtl/guarded_state_fsm.sv
// Guarded user-state register: applies requested target states only when legal, rejects others.
// Latency: accepted request updates out and pulses req_ack/req_err one cycle later (registered).
// Backpressure: req_ready = !locked; once locked, requests are never accepted until rst.
//
// Ports: clk/rst (sync, active-high); req_valid/req_state/req_ready request handshake;
// lock sets sticky locked; out = current state; req_ack/req_err/timeout_evt one-cycle pulses;
// fault = sticky illegal-encoding flag.
module guarded_state_fsm #(
    parameter int SW         = 3,
    parameter int NUM_STATES = 6,
    parameter int SAFE_STATE = 0,
    parameter int TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic [SW-1:0] req_state,
    output logic          req_ready,
    input  logic          lock,
    output logic [SW-1:0] out,
    output logic          req_ack,
    output logic          req_err,
    output logic          fault,
    output logic          locked,
    output logic          timeout_evt
);

    localparam logic [SW-1:0] SAFE   = SW'(SAFE_STATE);
    // One extra bit so NUM_STATES == 2**SW and s+1 overflow compare correctly.
    localparam logic [SW:0]   NS_EXT = (SW+1)'(NUM_STATES);

    logic [SW-1:0] out_q, out_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          fault_q, fault_d;
    logic          locked_q, locked_d;
    logic          tevt_q, tevt_d;

    logic          accept;
    logic          bad_enc;
    logic          legal;
    logic          tmo_hit;
    logic          cnt_clr;
    logic [SW:0]   cur_ext, nxt_ext, req_ext;

    always_comb begin
        cur_ext  = {1'b0, out_q};
        nxt_ext  = cur_ext + (SW+1)'(1);
        req_ext  = {1'b0, req_state};
        accept   = req_valid && !locked_q;
        bad_enc  = cur_ext >= NS_EXT;
        // Hold, step forward by one (if that state exists), or abort to safe.
        legal    = (req_state == out_q) || (req_state == SAFE) ||
                   ((nxt_ext < NS_EXT) && (req_ext == nxt_ext));

        out_d    = out_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        fault_d  = fault_q;
        locked_d = locked_q | lock;
        tevt_d   = 1'b0;

        if (bad_enc) begin
            // Corrupted encoding: recover first; a coincident request is consumed and rejected.
            out_d   = SAFE;
            fault_d = 1'b1;
            err_d   = accept;
        end else if (accept) begin
            if (legal) begin
                out_d = req_state;
                ack_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (tmo_hit) begin
            out_d  = SAFE;
            tevt_d = 1'b1;
        end

        cnt_clr = bad_enc || accept || (out_q == SAFE) || tmo_hit;
    end

    generate
        if (TIMEOUT > 0) begin : g_tmo
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] cnt_q, cnt_d;

            // Counter clears at TIMEOUT-1 via tmo_hit, so it never wraps.
            always_comb cnt_d = cnt_clr ? '0 : cnt_q + CW'(1);
            assign tmo_hit = (out_q != SAFE) && (cnt_q == CW'(TIMEOUT - 1));

            always_ff @(posedge clk) begin
                if (rst) cnt_q <= '0;
                else     cnt_q <= cnt_d;
            end
        end else begin : g_no_tmo
            assign tmo_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= SAFE;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            fault_q  <= 1'b0;
            locked_q <= 1'b0;
            tevt_q   <= 1'b0;
        end else begin
            out_q    <= out_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            fault_q  <= fault_d;
            locked_q <= locked_d;
            tevt_q   <= tevt_d;
        end
    end

    assign req_ready   = !locked_q;
    assign out         = out_q;
    assign req_ack     = ack_q;
    assign req_err     = err_q;
    assign fault       = fault_q;
    assign locked      = locked_q;
    assign timeout_evt = tevt_q;

endmodule

// File: tb/tb_guarded_state_fsm.sv
// Scoreboard bench for guarded_state_fsm: reference model pushes expected results at drive time.
// Latency: one cycle; expectations are popped and compared 1 time unit after the edge.
// Backpressure: req_ready checked against the model's lock state on every driven cycle.
module tb_guarded_state_fsm;

    localparam int SW   = 3;
    localparam int NS   = 6;
    localparam int SAFE = 0;
    localparam int TO   = 16;

    typedef struct {
        logic [SW-1:0] out;
        logic          ack;
        logic          err;
        logic          fault;
        logic          locked;
        logic          tevt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [SW-1:0] req_state = '0;
    logic          req_ready;
    logic          lock = 1'b0;
    logic [SW-1:0] out;
    logic          req_ack, req_err, fault, locked, timeout_evt;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    int   m_out = SAFE;
    int   m_cnt = 0;
    logic m_fault = 1'b0;
    logic m_locked = 1'b0;

    always #5 clk = ~clk;

    guarded_state_fsm #(.SW(SW), .NUM_STATES(NS), .SAFE_STATE(SAFE), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_state(req_state),
        .req_ready(req_ready), .lock(lock), .out(out), .req_ack(req_ack),
        .req_err(req_err), .fault(fault), .locked(locked), .timeout_evt(timeout_evt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance the model by one edge and queue what the DUT must show afterwards.
    task automatic model_step(input logic do_rst, input logic v, input int s, input logic lk);
        exp_t e;
        bit   acc, ok;
        if (do_rst) begin
            m_out = SAFE; m_cnt = 0; m_fault = 1'b0; m_locked = 1'b0;
            e = '{out: SW'(SAFE), ack: 1'b0, err: 1'b0, fault: 1'b0, locked: 1'b0, tevt: 1'b0};
        end else begin
            acc = v && !m_locked;
            e.ack = 1'b0; e.err = 1'b0; e.tevt = 1'b0;
            if (m_out >= NS) begin
                m_out = SAFE; m_fault = 1'b1; e.err = acc; m_cnt = 0;
            end else if (acc) begin
                ok = (s == m_out) || (s == SAFE) || (s == m_out + 1 && s < NS);
                if (ok) begin m_out = s; e.ack = 1'b1; end
                else    e.err = 1'b1;
                m_cnt = 0;
            end else if (m_out == SAFE) begin
                m_cnt = 0;
            end else if (m_cnt == TO - 1) begin
                m_out = SAFE; e.tevt = 1'b1; m_cnt = 0;
            end else begin
                m_cnt++;
            end
            m_locked = m_locked | lk;
            e.out = SW'(m_out); e.fault = m_fault; e.locked = m_locked;
        end
        sb.push_back(e);
    endtask

    task automatic pop_check(input bit with_out);
        exp_t e;
        if (sb.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            if (with_out) check_val("out", 32'(out), 32'(e.out));
            check_val("flags{ack,err,fault,locked,tevt}",
                      32'({req_ack, req_err, fault, locked, timeout_evt}),
                      32'({e.ack, e.err, e.fault, e.locked, e.tevt}));
        end
    endtask

    task automatic drive(input logic v, input int s, input logic lk);
        @(negedge clk);
        rst = 1'b0; req_valid = v; req_state = SW'(s); lock = lk;
        check_val("req_ready", 32'(req_ready), 32'(!m_locked));
        model_step(1'b0, v, s, lk);
        @(posedge clk); #1;
        pop_check(1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0; lock = 1'b0;
        model_step(1'b1, 1'b0, 0, 1'b0);
        @(posedge clk); #1;
        pop_check(1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset, then step 0->1->2->3
        do_reset();
        drive(1, 1, 0); drive(1, 2, 0); drive(1, 3, 0); idle(1);
        // Safe-state hold request is legal
        do_reset();
        drive(1, 0, 0); drive(1, 0, 0);
        // 2: illegal jumps and out-of-range, then abort
        drive(1, 1, 0); drive(1, 3, 0); drive(1, 7, 0); drive(1, 0, 0); idle(1);
        // Backward step (non-safe) is illegal
        drive(1, 1, 0); drive(1, 2, 0); drive(1, 1, 0);
        // 3: walk to top, request beyond range, abort
        do_reset();
        for (int k = 1; k < NS; k++) drive(1, k, 0);
        drive(1, 6, 0); drive(1, 5, 0); drive(1, 0, 0);
        // 4: timeout after 16 idle edges, then request at 15th restarts counter
        drive(1, 1, 0); drive(1, 2, 0); idle(17);
        drive(1, 1, 0); drive(1, 2, 0); idle(14); drive(1, 2, 0); idle(17);
        // Idle in safe state never times out
        idle(20);
        // 5: lock together with a request; later requests ignored; timeout still runs
        drive(1, 1, 1);
        drive(1, 2, 0); drive(1, 0, 0); drive(1, 3, 1);
        idle(15);
        do_reset();
        drive(1, 1, 0);
        // 6: corrupt the state register for one edge
        drive(1, 2, 0);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0; lock = 1'b0;
        force dut.out_q = 3'd7;
        m_out = 7;
        model_step(1'b0, 1'b0, 0, 1'b0);
        @(posedge clk); #1;
        release dut.out_q;
        pop_check(1'b0);
        idle(3);
        drive(1, 1, 0); drive(1, 2, 0);
        do_reset();
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/guarded_state_fsm.md
Name: guarded_state_fsm

Overview:
Parametrised successor to the single-input user FSM: user requests a target state over a valid/ready handshake, and the block applies it only if it is a legal transition from the current state. Illegal requests are rejected and flagged. Unreachable encodings are detected and recovered to a safe state. An idle timeout and a sticky lock complete the hardening. Sits between user-facing control logic and downstream mode decoders.

Parameters:
SW, 3, state/request width in bits
NUM_STATES, 6, legal states are 0..NUM_STATES-1 (2 <= NUM_STATES <= 2**SW)
SAFE_STATE, 0, recovery/abort state; must be < NUM_STATES
TIMEOUT, 16, cycles in a non-safe state without an accepted request before auto-return; 0 disables

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  1  user request present
req_state  input  SW  requested target state
req_ready  output  1  request can be accepted
lock  input  1  when high at a clk edge, sets the sticky lock
out  output  SW  current state, registered
req_ack  output  1  one-cycle pulse: previous accepted request applied
req_err  output  1  one-cycle pulse: previous accepted request rejected
fault  output  1  sticky: illegal state encoding detected
locked  output  1  sticky lock status
timeout_evt  output  1  one-cycle pulse: auto-return taken

Behaviour:
- Reset (rst=1 at edge): out=SAFE_STATE, req_ack=0, req_err=0, fault=0, locked=0, timeout_evt=0, timeout counter=0. rst overrides all other inputs.
- req_ready = !locked, combinational from the locked register. A request is accepted when req_valid && req_ready at an edge.
- Legal targets from current state s: s (hold), s+1 only if s+1 < NUM_STATES, and SAFE_STATE (abort). Every other target is illegal, including any value >= NUM_STATES.
- Legal accepted request: out takes req_state at that edge, and req_ack=1 for exactly the next cycle.
- Illegal accepted request: out is unchanged and req_err=1 for exactly the next cycle. req_ack and req_err are never high together.
- Not accepted (no valid, or locked): out holds and no ack or err pulse is produced.
- Lock: lock=1 at an edge sets locked=1 from the next cycle. It clears only on rst. A request and a lock rising at the same edge: the request is still accepted, because ready reflects the old lock value.
- Illegal encoding: if out >= NUM_STATES at an edge (state corruption, not reachable by legal transitions), out is set to SAFE_STATE and fault is set sticky. Any request at that edge is accepted and rejected with req_err=1. This check has priority over request handling and timeout. It applies whether or not the block is locked.
- Timeout (TIMEOUT>0):
  - The counter increments each cycle while out != SAFE_STATE and no request is accepted.
  - It clears on any accepted request, legal or illegal, and whenever out == SAFE_STATE.
  - When the counter reaches TIMEOUT-1 and increments: out becomes SAFE_STATE, timeout_evt=1 for the next cycle, and the counter clears.
  - An accepted request at the same edge wins and no timeout occurs.
  - The timeout also runs while locked, so a locked block still falls back to safe.
- Counter width is clog2(TIMEOUT+1) and it never wraps. With TIMEOUT=0 the counter logic is absent and timeout_evt is tied to 0.
- Priority per edge: rst > illegal-encoding recovery > accepted request > timeout > hold.
- Safe state: requesting SAFE_STATE while already in SAFE_STATE is a legal hold and produces req_ack.

Test Plan:
1. Defaults, reset, then requests 1, 2, 3 on consecutive cycles -> out steps 0->1->2->3, with req_ack high one cycle after each request; no req_err.
2. From out=1, request 3, then request 7 -> out stays 1, req_err pulses twice, req_ack stays 0; then request 0 -> out=0 and req_ack=1.
3. Step to out=5 and request 6 (6 >= NUM_STATES) -> out stays 5 and req_err=1; then request 0 (abort) -> out=0.
4. Step to out=2, then hold with req_valid=0 for 16 cycles -> out=0 on the 16th edge and timeout_evt=1 for one cycle. A repeat run with a request at cycle 15 gives no timeout, and the counter restarts.
5. Assert lock with req_valid=1 at the same edge -> that request is acked and locked=1. Subsequent requests are ignored: req_ready=0 and no pulses. rst then clears locked.
6. Force out to 7 via hierarchical force for one edge, then release -> the next cycle has out=0 and fault=1; fault remains 1 until rst.
